// File: rtl/xor_stream_cipher_gen2_if.sv
// Channel bundle for one cipher direction: input word handshake plus output word handshake.
interface xor_stream_cipher_gen2_if #(
    parameter int DATA_W = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;

    // Producer of input words and consumer of output words
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    // The cipher block itself
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/xor_stream_cipher_gen2.sv
// Two-channel XOR stream cipher. A serially loaded key seeds independent
// Galois LFSR keystreams for the tx and rx channels; each accepted word is
// XORed with the low LFSR bits and the LFSR advances DATA_W steps.
module xor_stream_cipher_gen2 #(
    parameter int              KEY_W  = 32,
    parameter int              DATA_W = 8,
    parameter logic [KEY_W-1:0] POLY  = 32'h8020_0003,
    parameter int              HB_W   = 24
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cfg_en,
    input  logic                     cfg_i,
    output logic                     cfg_o,
    output logic                     keyed,
    xor_stream_cipher_gen2_if.slave  tx,
    xor_stream_cipher_gen2_if.slave  rx,
    output logic [2:0]               heartbeat
);

    typedef enum logic [1:0] {
        UNKEYED,
        LOADING,
        RUN
    } state_t;

    state_t              r_state;
    logic [KEY_W-1:0]    r_key;
    logic                r_keyed;
    logic [KEY_W-1:0]    r_tx_lfsr;
    logic [KEY_W-1:0]    r_rx_lfsr;
    logic                r_tx_vld;
    logic                r_rx_vld;
    logic [DATA_W-1:0]   r_tx_data;
    logic [DATA_W-1:0]   r_rx_data;
    logic [HB_W-1:0]     r_hb;

    logic                w_run;
    logic                w_seed;
    logic [KEY_W-1:0]    w_seed_val;
    logic                w_tx_rdy;
    logic                w_rx_rdy;
    logic                w_tx_acc;
    logic                w_rx_acc;
    logic [KEY_W-1:0]    w_tx_next;
    logic [KEY_W-1:0]    w_rx_next;

    // DATA_W Galois steps unrolled into one combinational advance
    function automatic logic [KEY_W-1:0] f_advance(input logic [KEY_W-1:0] s);
        logic [KEY_W-1:0] v;
        v = s;
        for (int unsigned i = 0; i < DATA_W; i++) begin
            v = v[0] ? ((v >> 1) ^ POLY) : (v >> 1);
        end
        return v;
    endfunction

    assign w_run      = (r_state == RUN);
    assign w_seed     = (r_state == LOADING) && !cfg_en;
    // An all-zero key would lock the LFSR at zero, so it seeds with 1 instead
    assign w_seed_val = (r_key == '0) ? KEY_W'(1) : r_key;

    assign w_tx_rdy   = w_run & (~r_tx_vld | tx.out_ready);
    assign w_rx_rdy   = w_run & (~r_rx_vld | rx.out_ready);
    assign w_tx_acc   = tx.in_valid & w_tx_rdy;
    assign w_rx_acc   = rx.in_valid & w_rx_rdy;
    assign w_tx_next  = f_advance(r_tx_lfsr);
    assign w_rx_next  = f_advance(r_rx_lfsr);

    assign tx.in_ready  = w_tx_rdy;
    assign tx.out_valid = r_tx_vld;
    assign tx.out_data  = r_tx_data;
    assign rx.in_ready  = w_rx_rdy;
    assign rx.out_valid = r_rx_vld;
    assign rx.out_data  = r_rx_data;

    assign cfg_o     = r_key[KEY_W-1];
    assign keyed     = r_keyed;
    assign heartbeat = r_hb[HB_W-1:HB_W-3];

    // Key shift register and UNKEYED/LOADING/RUN control with registered keyed flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= UNKEYED;
            r_key   <= '0;
            r_keyed <= 1'b0;
        end else if (cfg_en) begin
            r_key   <= {r_key[KEY_W-2:0], cfg_i};
            r_state <= LOADING;
            r_keyed <= 1'b0;
        end else if (r_state == LOADING) begin
            r_state <= RUN;
            r_keyed <= 1'b1;
        end
    end

    // tx channel: keystream state and single-entry output register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_lfsr <= KEY_W'(1);
            r_tx_vld  <= 1'b0;
            r_tx_data <= '0;
        end else begin
            if (w_seed) begin
                r_tx_lfsr <= w_seed_val;
            end else if (w_tx_acc) begin
                r_tx_lfsr <= w_tx_next;
            end
            if (cfg_en) begin
                r_tx_vld <= 1'b0;
            end else if (w_tx_acc) begin
                r_tx_vld  <= 1'b1;
                r_tx_data <= tx.in_data ^ r_tx_lfsr[DATA_W-1:0];
            end else if (tx.out_ready) begin
                r_tx_vld <= 1'b0;
            end
        end
    end

    // rx channel: keystream state and single-entry output register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_lfsr <= KEY_W'(1);
            r_rx_vld  <= 1'b0;
            r_rx_data <= '0;
        end else begin
            if (w_seed) begin
                r_rx_lfsr <= w_seed_val;
            end else if (w_rx_acc) begin
                r_rx_lfsr <= w_rx_next;
            end
            if (cfg_en) begin
                r_rx_vld <= 1'b0;
            end else if (w_rx_acc) begin
                r_rx_vld  <= 1'b1;
                r_rx_data <= rx.in_data ^ r_rx_lfsr[DATA_W-1:0];
            end else if (rx.out_ready) begin
                r_rx_vld <= 1'b0;
            end
        end
    end

    // Free-running heartbeat counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hb <= '0;
        end else begin
            r_hb <= r_hb + 1'b1;
        end
    end

endmodule

// File: tb/tb_xor_stream_cipher_gen2.sv
// Self-checking bench for xor_stream_cipher_gen2 with default parameters.
module tb_xor_stream_cipher_gen2;

    localparam logic [31:0] POLY = 32'h8020_0003;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cfg_en;
    logic       cfg_i;
    logic       cfg_o;
    logic       keyed;
    logic [2:0] heartbeat;

    xor_stream_cipher_gen2_if #(.DATA_W(8)) tx_if ();
    xor_stream_cipher_gen2_if #(.DATA_W(8)) rx_if ();

    xor_stream_cipher_gen2 #(
        .KEY_W (32),
        .DATA_W(8),
        .POLY  (POLY),
        .HB_W  (24)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cfg_en   (cfg_en),
        .cfg_i    (cfg_i),
        .cfg_o    (cfg_o),
        .keyed    (keyed),
        .tx       (tx_if),
        .rx       (rx_if),
        .heartbeat(heartbeat)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state: loaded key and both keystream registers
    logic [31:0] m_key;
    logic [31:0] m_tx;
    logic [31:0] m_rx;

    logic [7:0] q_tx[$];
    logic [7:0] q_rx[$];

    typedef struct {
        logic [31:0] key;
        logic [7:0]  din;
        logic [7:0]  exp;
    } vec_t;

    vec_t vecs[6];

    function automatic logic [31:0] ks_next(input logic [31:0] s);
        logic [31:0] v;
        v = s;
        for (int i = 0; i < 8; i++) begin
            if ((v & 32'd1) != 0) v = (v >> 1) ^ POLY;
            else                  v = v >> 1;
        end
        return v;
    endfunction

    function automatic logic [31:0] seed_of(input logic [31:0] k);
        return (k == 32'd0) ? 32'd1 : k;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_keyed"},    64'(keyed), 64'd0);
        check({tag, "_cfg_o"},    64'(cfg_o), 64'd0);
        check({tag, "_tx_rdy"},   64'(tx_if.in_ready), 64'd0);
        check({tag, "_rx_rdy"},   64'(rx_if.in_ready), 64'd0);
        check({tag, "_tx_vld"},   64'(tx_if.out_valid), 64'd0);
        check({tag, "_rx_vld"},   64'(rx_if.out_valid), 64'd0);
        check({tag, "_tx_data"},  64'(tx_if.out_data), 64'd0);
        check({tag, "_rx_data"},  64'(rx_if.out_data), 64'd0);
        check({tag, "_hb"},       64'(heartbeat), 64'd0);
    endtask

    // Shift a full key MSB-first; cfg_o must replay the previous key
    task automatic load_key(input logic [31:0] k);
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            cfg_en = 1'b1;
            cfg_i  = k[31-i];
            #1;
            check("cfg_o_old_key", 64'(cfg_o), 64'(m_key[31]));
            if (i > 0) begin
                check("load_tx_rdy", 64'(tx_if.in_ready), 64'd0);
                check("load_rx_rdy", 64'(rx_if.in_ready), 64'd0);
                check("load_tx_vld", 64'(tx_if.out_valid), 64'd0);
            end
            m_key = {m_key[30:0], k[31-i]};
        end
        @(negedge clk);
        cfg_en = 1'b0;
        cfg_i  = 1'b0;
        #1;
        check("keyed_during_load", 64'(keyed), 64'd0);
        @(negedge clk);
        #1;
        check("keyed_after_load", 64'(keyed), 64'd1);
        m_tx = seed_of(m_key);
        m_rx = seed_of(m_key);
    endtask

    task automatic tx_xfer(input logic [7:0] d, input logic [7:0] exp, output logic [7:0] got);
        int cnt;
        @(negedge clk);
        tx_if.in_valid  = 1'b1;
        tx_if.in_data   = d;
        tx_if.out_ready = 1'b1;
        #1;
        cnt = 0;
        while (!tx_if.in_ready && cnt < 20) begin
            @(negedge clk);
            #1;
            cnt++;
        end
        if (cnt >= 20) check("tx_accept_timeout", 64'd0, 64'd1);
        m_tx = ks_next(m_tx);
        @(negedge clk);
        tx_if.in_valid = 1'b0;
        #1;
        check("tx_out_valid", 64'(tx_if.out_valid), 64'd1);
        check("tx_out_data", 64'(tx_if.out_data), 64'(exp));
        got = tx_if.out_data;
    endtask

    task automatic rx_xfer(input logic [7:0] d, input logic [7:0] exp);
        int cnt;
        @(negedge clk);
        rx_if.in_valid  = 1'b1;
        rx_if.in_data   = d;
        rx_if.out_ready = 1'b1;
        #1;
        cnt = 0;
        while (!rx_if.in_ready && cnt < 20) begin
            @(negedge clk);
            #1;
            cnt++;
        end
        if (cnt >= 20) check("rx_accept_timeout", 64'd0, 64'd1);
        m_rx = ks_next(m_rx);
        @(negedge clk);
        rx_if.in_valid = 1'b0;
        #1;
        check("rx_out_valid", 64'(rx_if.out_valid), 64'd1);
        check("rx_out_data", 64'(rx_if.out_data), 64'(exp));
    endtask

    // Per-cycle scoreboard step for both channels; called #1 after a negedge
    task automatic score_cycle();
        logic [7:0] e;
        if (tx_if.out_valid && tx_if.out_ready) begin
            if (q_tx.size() == 0) check("rnd_tx_unexpected", 64'(tx_if.out_data), 64'hFFFF);
            else begin
                e = q_tx.pop_front();
                check("rnd_tx_data", 64'(tx_if.out_data), 64'(e));
            end
        end
        if (rx_if.out_valid && rx_if.out_ready) begin
            if (q_rx.size() == 0) check("rnd_rx_unexpected", 64'(rx_if.out_data), 64'hFFFF);
            else begin
                e = q_rx.pop_front();
                check("rnd_rx_data", 64'(rx_if.out_data), 64'(e));
            end
        end
        check("rnd_tx_rdy", 64'(tx_if.in_ready), 64'(!tx_if.out_valid || tx_if.out_ready));
        check("rnd_rx_rdy", 64'(rx_if.in_ready), 64'(!rx_if.out_valid || rx_if.out_ready));
        if (tx_if.in_valid && tx_if.in_ready) begin
            q_tx.push_back(tx_if.in_data ^ m_tx[7:0]);
            m_tx = ks_next(m_tx);
        end
        if (rx_if.in_valid && rx_if.in_ready) begin
            q_rx.push_back(rx_if.in_data ^ m_rx[7:0]);
            m_rx = ks_next(m_rx);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0] got;
        logic [7:0] e1;
        logic [7:0] e2;

        vecs[0] = '{key: 32'h0000_0001, din: 8'h41, exp: 8'h40};
        vecs[1] = '{key: 32'h0000_0000, din: 8'h41, exp: 8'h40};
        vecs[2] = '{key: 32'hDB36_C002, din: 8'h41, exp: 8'h43};
        vecs[3] = '{key: 32'hFFFF_FF00, din: 8'hA5, exp: 8'hA5};
        vecs[4] = '{key: 32'h1234_56FF, din: 8'h00, exp: 8'hFF};
        vecs[5] = '{key: 32'h8000_003C, din: 8'hC3, exp: 8'hFF};

        rst_n = 1'b0;
        cfg_en = 1'b0;
        cfg_i = 1'b0;
        tx_if.in_valid = 1'b0; tx_if.in_data = '0; tx_if.out_ready = 1'b0;
        rx_if.in_valid = 1'b0; rx_if.in_data = '0; rx_if.out_ready = 1'b0;
        m_key = '0; m_tx = 32'd1; m_rx = 32'd1;
        #3;
        check_reset_outputs("rst");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("unkeyed_tx_rdy", 64'(tx_if.in_ready), 64'd0);

        // Known-answer keystream for key 1, two words
        load_key(32'h0000_0001);
        tx_xfer(8'h41, 8'h40, got);
        tx_xfer(8'h41, 8'h43, got);

        // Loopback: tx ciphertext through freshly keyed rx recovers plaintext
        load_key(32'h0000_0001);
        tx_xfer(8'h41, 8'h40, got);
        rx_xfer(got, 8'h41);
        tx_xfer(8'h41, 8'h43, got);
        rx_xfer(got, 8'h41);

        // First-word table across keys, including the zero-key guard
        foreach (vecs[i]) begin
            load_key(vecs[i].key);
            tx_xfer(vecs[i].din, vecs[i].exp, got);
        end

        // Backpressure: output held, no loss or duplication
        load_key(32'hCAFE_BABE);
        e1 = 8'h11 ^ m_tx[7:0];
        m_tx = ks_next(m_tx);
        e2 = 8'h22 ^ m_tx[7:0];
        m_tx = ks_next(m_tx);
        @(negedge clk);
        tx_if.in_valid = 1'b1; tx_if.in_data = 8'h11; tx_if.out_ready = 1'b0;
        #1;
        check("bp_rdy_idle", 64'(tx_if.in_ready), 64'd1);
        @(negedge clk);
        tx_if.in_data = 8'h22;
        #1;
        check("bp_first_vld", 64'(tx_if.out_valid), 64'd1);
        check("bp_first_data", 64'(tx_if.out_data), 64'(e1));
        check("bp_blocked_rdy", 64'(tx_if.in_ready), 64'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            check("bp_hold_data", 64'(tx_if.out_data), 64'(e1));
            check("bp_hold_rdy", 64'(tx_if.in_ready), 64'd0);
        end
        @(negedge clk);
        tx_if.out_ready = 1'b1;
        #1;
        check("bp_release_rdy", 64'(tx_if.in_ready), 64'd1);
        @(negedge clk);
        tx_if.in_valid = 1'b0;
        #1;
        check("bp_second_vld", 64'(tx_if.out_valid), 64'd1);
        check("bp_second_data", 64'(tx_if.out_data), 64'(e2));
        @(negedge clk);
        #1;
        check("bp_drained", 64'(tx_if.out_valid), 64'd0);

        // Rekey with an output pending: discarded, old key shifts out, keystream restarts
        @(negedge clk);
        tx_if.in_valid = 1'b1; tx_if.in_data = 8'h33; tx_if.out_ready = 1'b0;
        @(negedge clk);
        tx_if.in_valid = 1'b0;
        #1;
        check("rekey_pending_vld", 64'(tx_if.out_valid), 64'd1);
        load_key(32'h0000_5A5A);
        tx_xfer(8'h00, 8'h5A, got);
        tx_xfer(8'h00, 8'(m_tx[7:0]), got);

        // Randomized concurrent traffic on both channels
        load_key($urandom);
        for (int cyc = 0; cyc < 600; cyc++) begin
            @(negedge clk);
            tx_if.in_valid  = ($urandom_range(0, 3) != 0);
            tx_if.in_data   = 8'($urandom);
            tx_if.out_ready = ($urandom_range(0, 3) != 0);
            rx_if.in_valid  = ($urandom_range(0, 2) != 0);
            rx_if.in_data   = 8'($urandom);
            rx_if.out_ready = ($urandom_range(0, 2) != 0);
            #1;
            score_cycle();
        end
        for (int cyc = 0; cyc < 4; cyc++) begin
            @(negedge clk);
            tx_if.in_valid = 1'b0; tx_if.out_ready = 1'b1;
            rx_if.in_valid = 1'b0; rx_if.out_ready = 1'b1;
            #1;
            score_cycle();
        end
        check("rnd_tx_queue_empty", 64'(q_tx.size()), 64'd0);
        check("rnd_rx_queue_empty", 64'(q_rx.size()), 64'd0);

        // Async reset in the middle of a key shift
        tx_xfer(8'h5C, 8'(8'h5C ^ m_tx[7:0]), got);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            cfg_en = 1'b1;
            cfg_i  = 1'($urandom_range(0, 1));
        end
        #2;
        rst_n = 1'b0;
        #1;
        m_key = '0; m_tx = 32'd1; m_rx = 32'd1;
        check_reset_outputs("async_rst");
        @(negedge clk);
        cfg_en = 1'b0;
        rst_n  = 1'b1;
        tx_if.in_valid = 1'b1; tx_if.out_ready = 1'b1;
        rx_if.in_valid = 1'b1; rx_if.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            check("post_rst_tx_rdy", 64'(tx_if.in_ready), 64'd0);
            check("post_rst_rx_rdy", 64'(rx_if.in_ready), 64'd0);
            check("post_rst_keyed", 64'(keyed), 64'd0);
        end
        tx_if.in_valid = 1'b0;
        rx_if.in_valid = 1'b0;
        load_key(32'h1357_2468);
        tx_xfer(8'hF0, 8'h98, got);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/xor_stream_cipher_gen2.md
XOR_STREAM_CIPHER_GEN2 -- requirements
Module: xor_stream_cipher_gen2

Interface
REQ-001 SHALL have parameter KEY_W, default 32: key and LFSR width, range 16..64.
REQ-002 SHALL have parameter DATA_W, default 8: channel word width, 1..KEY_W/2.
REQ-003 SHALL have parameter POLY, default 32'h8020_0003: Galois feedback mask, KEY_W bits.
REQ-004 SHALL have parameter HB_W, default 24: heartbeat counter width, >=3.
REQ-005 SHALL have these ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
cfg_en  in  1  key shift enable
cfg_i  in  1  serial key bit, MSB first
cfg_o  out  1  key[KEY_W-1], shift-out/readback
keyed  out  1  key loaded, channels running
tx_in_valid / tx_in_ready  in / out  1  plaintext handshake
tx_in_data  in  DATA_W  plaintext
tx_out_valid / tx_out_ready  out / in  1  ciphertext handshake
tx_out_data  out  DATA_W  ciphertext
rx_in_valid / rx_in_ready  in / out  1  ciphertext handshake
rx_in_data  in  DATA_W  ciphertext
rx_out_valid / rx_out_ready  out / in  1  plaintext handshake
rx_out_data  out  DATA_W  plaintext
heartbeat  out  3  counter bits [HB_W-1:HB_W-3]

Function
REQ-006 SHALL implement states UNKEYED, LOADING, RUN; UNKEYED->LOADING and RUN->LOADING on cfg_en=1; LOADING->RUN on the first cycle cfg_en=0.
REQ-007 SHALL, each cycle cfg_en=1, shift key <= {key[KEY_W-2:0], cfg_i}.
REQ-008 SHALL, on LOADING->RUN, seed tx and rx LFSRs with key, or with 1 if key==0 (zero-lock guard), and set keyed=1.
REQ-009 SHALL hold in_ready=0 on both channels in UNKEYED and LOADING.
REQ-010 SHALL clear both out_valid flags on every cycle cfg_en=1, discarding pending outputs.
REQ-011 SHALL, per channel, drive in_ready = RUN & (!out_valid | out_ready).
REQ-012 SHALL, on accept (in_valid & in_ready), register out_data = in_data XOR lfsr[DATA_W-1:0] and set out_valid=1, giving 1-cycle latency at 1 word/cycle.
REQ-013 SHALL, on accept, advance that channel's LFSR by exactly DATA_W Galois steps in one cycle; per step s = s[0] ? (s>>1)^POLY : s>>1.
REQ-014 SHALL clear out_valid when out_ready=1 and no accept occurs; out_data is held while out_valid=1 and out_ready=0.
REQ-015 SHALL keep tx and rx LFSRs independent; each advances only on its own accept.
REQ-016 SHALL increment the heartbeat counter every cycle with modulo-2^HB_W wrap, independent of state.

Reset
REQ-017 SHALL, on rst_n=0, asynchronously set state=UNKEYED, key=0, LFSRs=1, keyed=0, cfg_o=0, all out_valid=0, all out_data=0, heartbeat counter=0.
REQ-018 SHALL force in_ready=0 and keyed=0 while rst_n=0.

Verification (KEY_W=32, DATA_W=8, defaults)
REQ-019 SHALL cover: after reset, shift key 0x00000001 (32 cycles) then drop cfg_en -> keyed=1 next cycle; tx words 0x41, 0x41 -> tx_out_data 0x40, then 0x43 (LFSR 0x00000001 -> 0xDB36C002).
REQ-020 SHALL cover loopback: tx_out_data fed to rx_in after the same key -> rx_out_data 0x41, 0x41.
REQ-021 SHALL cover key 0x00000000 -> same keystream as key 0x00000001 (0x41 -> 0x40).
REQ-022 SHALL cover backpressure: tx_out_ready=0 with output pending -> tx_in_ready=0, tx_out_data stable; ready=1 -> stream resumes with no word lost or duplicated.
REQ-023 SHALL cover rekey mid-stream: cfg_en=1 with tx_out_valid=1 -> tx_out_valid=0 next cycle; cfg_o shows old key MSB-first; after reload keystream restarts from new key.
REQ-024 SHALL cover async reset with cfg_en=1 mid-shift -> all outputs at REQ-017 values immediately, keyed=0, and in_ready held 0 until a full reload.
